// File: rtl/clk_wiz.sv
// clk_wiz: even-ratio clock divider (w_clk -> w_clk_out, 50% duty) with w_ce pulse on each output rise and w_locked after LOCK_CYCLES output periods; sync active-high w_rst
module clk_wiz #(
  parameter int DIV = 2,
  parameter int LOCK_CYCLES = 16,
  parameter int CNT_W = 16
) (
  input  logic w_clk,
  input  logic w_rst,
  output logic w_clk_out,
  output logic w_locked,
  output logic w_ce
);
  logic [CNT_W-1:0] cnt_q = '0;
  logic [CNT_W-1:0] lock_q = '0;
  logic clk_q = 1'b0;
  logic ce_q = 1'b0;
  logic locked_q = 1'b0;
  logic [CNT_W-1:0] cnt_d, lock_d;
  logic clk_d, locked_d, wrap;
  always_comb begin
    wrap = cnt_q == CNT_W'(DIV - 1);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    clk_d = wrap ? 1'b1 : (cnt_q == CNT_W'(DIV / 2 - 1)) ? 1'b0 : clk_q;
    lock_d = (wrap && lock_q != CNT_W'(LOCK_CYCLES)) ? lock_q + 1'b1 : lock_q;
    locked_d = locked_q | (lock_d == CNT_W'(LOCK_CYCLES));
  end
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      cnt_q <= '0;
      lock_q <= '0;
      clk_q <= 1'b0;
      ce_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lock_q <= lock_d;
      clk_q <= clk_d;
      ce_q <= wrap;
      locked_q <= locked_d;
    end
  end
  assign w_clk_out = clk_q;
  assign w_ce = ce_q;
  assign w_locked = locked_q;
endmodule

// File: tb/tb_clk_wiz.sv
// tb_clk_wiz: directed self-checking bench for clk_wiz at DIV=2/16, DIV=4/3 and DIV=10/16
module tb_clk_wiz;
  logic clk = 1'b0;
  logic rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
  logic co0, lk0, ce0, co1, lk1, ce1, co2, lk2, ce2;
  int n = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clk_wiz u0 (.w_clk(clk), .w_rst(rst0), .w_clk_out(co0), .w_locked(lk0), .w_ce(ce0));
  clk_wiz #(.DIV(4), .LOCK_CYCLES(3)) u1 (.w_clk(clk), .w_rst(rst1), .w_clk_out(co1), .w_locked(lk1), .w_ce(ce1));
  clk_wiz #(.DIV(10)) u2 (.w_clk(clk), .w_rst(rst2), .w_clk_out(co2), .w_locked(lk2), .w_ce(ce2));

  task automatic check(input string tag, input int k, input logic obs, input logic exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check0(input int k, input logic ec, input logic ee, input logic el);
    check("d0_clk_out", k, co0, ec);
    check("d0_ce", k, ce0, ee);
    check("d0_locked", k, lk0, el);
  endtask

  initial begin
    #1;
    check0(0, 1'b0, 1'b0, 1'b0);
    check("d1_powerup_clk_out", 0, co1, 1'b0);
    check("d2_powerup_locked", 0, lk2, 1'b0);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check0(-i, 1'b0, 1'b0, 1'b0);
      check("d1_rst_clk_out", -i, co1, 1'b0);
      check("d2_rst_ce", -i, ce2, 1'b0);
    end
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    for (int k = 1; k <= 1040; k++) begin
      step();
      check0(k, k % 2 == 0, k % 2 == 0, k >= 32);
      if (k <= 40) begin
        check("d1_clk_out", k, co1, k >= 4 && (k % 4 == 0 || k % 4 == 1));
        check("d1_ce", k, ce1, k % 4 == 0);
        check("d1_locked", k, lk1, k >= 12);
      end
      if (k <= 1000) begin
        check("d2_clk_out", k, co2, k >= 10 && k % 10 < 5);
        check("d2_ce", k, ce2, k % 10 == 0);
      end
    end
    check("d0_pre_mid_reset_high", 1040, co0, 1'b1);
    rst0 = 1'b1;
    step();
    check0(0, 1'b0, 1'b0, 1'b0);
    rst0 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      check0(k, k % 2 == 0, k % 2 == 0, k >= 32);
    end
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check0(k, k % 2 == 0, k % 2 == 0, 1'b0);
    end
    rst0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check0(-i, 1'b0, 1'b0, 1'b0);
    end
    rst0 = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      step();
      check0(k, k % 2 == 0, k % 2 == 0, k >= 32);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/clk_wiz.md
Name: clk_wiz

Overview:
- Fully synchronous clock generator replacing the vendor clocking wizard at the top level of the processor board design.
- Divides the board clock (100 MHz) by an even integer to produce the system clock (50 MHz by default), which drives the processor, the cycle counter and the 7-segment controller.
- Asserts a lock flag once the output has run stably for a programmable number of periods. The top level derives its processor reset from the inverse of this lock flag.

Parameters:
- DIV, 2, division ratio of the input clock. Must be even and >= 2; output is high for DIV/2 and low for DIV/2 input cycles.
- LOCK_CYCLES, 16, number of output-clock rising edges after reset release before w_locked asserts. Must be >= 1.
- CNT_W, 16, width of the internal divide and lock counters. Must hold both DIV-1 and LOCK_CYCLES.

Ports:
- w_clk  input  1  board clock (100 MHz); all state updates on its rising edge.
- w_rst  input  1  synchronous active-high reset.
- w_clk_out  output  1  divided clock, registered, 50% duty.
- w_locked  output  1  high once the output is stable; low while unlocked or in reset.
- w_ce  output  1  one-w_clk-cycle pulse, registered, high during the w_clk cycle in which w_clk_out has just risen.

Behaviour:
- Reset (w_rst=1 at a w_clk edge): divide counter cnt=0, w_clk_out=0, w_ce=0, lock counter=0, w_locked=0. All outputs are registers; no combinational paths from inputs to outputs.
- Divide counter, each non-reset edge: cnt <= (cnt==DIV-1) ? 0 : cnt+1.
- Clock output, each non-reset edge:
  - cnt==DIV-1: w_clk_out <= 1.
  - cnt==DIV/2-1: w_clk_out <= 0.
  - Otherwise w_clk_out holds.
- Resulting timing: the first rising edge of w_clk_out occurs at the DIV-th w_clk edge after reset release. Period is exactly DIV w_clk cycles with duty 50%. For DIV=2 the output toggles every edge.
- w_ce: w_ce <= (cnt==DIV-1) on non-reset edges, so it is high exactly one w_clk cycle per output period.
- Lock counter:
  - Increments on every edge where cnt==DIV-1 and the counter is below LOCK_CYCLES; it saturates at LOCK_CYCLES.
  - w_locked <= 1 on the same edge at which the counter reaches LOCK_CYCLES, i.e. w_clk edge DIV*LOCK_CYCLES after reset release (edge 32 for the defaults).
  - w_locked then stays 1 until the next reset.
- Reset mid-operation: takes effect at the next w_clk edge regardless of phase. w_clk_out is forced low even if it was high (a shortened high phase is permitted), w_locked drops immediately, and the lock sequence restarts from zero after release.
- Reset held for many cycles: all outputs stay 0; counters do not advance.
- Power-up: all registers carry initial value 0 so that behaviour is defined in simulation before any reset.
- Synthesis: w_clk_out is used as a clock net downstream; it must come directly from a single flip-flop (no gating logic).

Test Plan:
- Defaults, w_rst=1 for 5 edges then 0 → w_clk_out, w_ce and w_locked all 0 during reset. w_clk_out first rises at edge 2 after release, then toggles every edge; w_ce high on edges 2, 4, 6, …
- Defaults, count edges after release → w_locked 0 through edge 31 and 1 from edge 32 onward. It stays 1 for 1000 further edges.
- Defaults, locked and w_clk_out=1, assert w_rst for 1 edge → next edge gives w_clk_out=0 and w_locked=0. After release w_locked re-asserts exactly 32 edges later.
- DIV=4, LOCK_CYCLES=3, reset then release → w_clk_out pattern 0,0,0,1,1,0,0,1,1… starting from edge 1, with the first rise at edge 4. w_ce high at edges 4, 8, 12. w_locked rises at edge 12.
- DIV=10 (100 MHz → 10 MHz) → high 5 cycles, low 5 cycles, with w_ce period 10 over 100 periods.
- Reset asserted at edge 20 (before lock, defaults) → w_locked never rises before edge 20+1+32 after release timing restarts. No w_ce pulses while reset is held.
